// File: rtl/cm_lane_fifo_pkg.sv
// Shared CM helpers: width derivation used by the lane FIFO and its read-side gather.
package cm_lane_fifo_pkg;

    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Bits needed to hold a count in 0..max_val inclusive.
    function automatic int unsigned count_width(input int unsigned max_val);
        return ceil_log2(max_val + 1);
    endfunction

endpackage

// File: rtl/cm_lane_sel.sv
// Read-side lane gather: presents lanes starting at rptr, zeroing lanes beyond lane_cnt.
module cm_lane_sel
    import cm_lane_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LANES   = 4,
    parameter int unsigned DEPTH      = 32,
    localparam int unsigned ADDR_WIDTH = ceil_log2(DEPTH),
    localparam int unsigned RN_WIDTH   = count_width(RD_LANES)
) (
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
    input  logic [ADDR_WIDTH-1:0]            rptr,
    input  logic [RN_WIDTH-1:0]              lane_cnt,
    output logic [RD_LANES*DATA_WIDTH-1:0]   data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < RD_LANES; i++) begin
            if (i < int'(lane_cnt)) begin
                // Address arithmetic wraps naturally at the power-of-two depth.
                data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rptr + ADDR_WIDTH'(i)];
            end
        end
    end

endmodule

// File: rtl/cm_lane_fifo.sv
// Multi-lane FIFO: up to WR_LANES lanes written and RD_LANES lanes consumed per cycle.
module cm_lane_fifo
    import cm_lane_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WR_LANES   = 4,
    parameter int unsigned RD_LANES   = 4,
    parameter int unsigned DEPTH      = 32,
    localparam int unsigned ADDR_WIDTH = ceil_log2(DEPTH),
    localparam int unsigned CNT_WIDTH  = count_width(DEPTH),
    localparam int unsigned WN_WIDTH   = count_width(WR_LANES),
    localparam int unsigned RN_WIDTH   = count_width(RD_LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           src_vld,
    input  logic [WN_WIDTH-1:0]            src_num,
    input  logic [WR_LANES*DATA_WIDTH-1:0] src_data,
    output logic                           src_rdy,
    input  logic                           dst_rdy,
    input  logic [RN_WIDTH-1:0]            dst_num,
    output logic                           dst_vld,
    output logic [RD_LANES*DATA_WIDTH-1:0] dst_data,
    output logic [RN_WIDTH-1:0]            dst_cnt,
    input  logic [CNT_WIDTH-1:0]           afull_th,
    input  logic [CNT_WIDTH-1:0]           aempty_th,
    output logic                           afull,
    output logic                           aempty,
    output logic                           ovfl,
    output logic                           udfl,
    output logic [CNT_WIDTH-1:0]           cnt
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [ADDR_WIDTH-1:0]            wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]            rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
    logic                             src_rdy_q, src_rdy_d;
    logic                             dst_vld_q, dst_vld_d;
    logic                             afull_q, afull_d;
    logic                             aempty_q, aempty_d;
    logic                             wr_en, rd_en;
    logic [WN_WIDTH-1:0]              wr_n;
    logic [RN_WIDTH-1:0]              rd_n;

    assign dst_cnt = (cnt_q > CNT_WIDTH'(RD_LANES)) ? RN_WIDTH'(RD_LANES) : RN_WIDTH'(cnt_q);

    assign wr_en = src_vld & src_rdy_q;
    assign rd_en = dst_vld_q & dst_rdy;
    assign wr_n  = wr_en ? src_num : '0;
    // An over-read still drains whatever is presented.
    assign rd_n  = rd_en ? ((dst_num < dst_cnt) ? dst_num : dst_cnt) : '0;

    assign ovfl = src_vld & ~src_rdy_q & (src_num != '0);
    assign udfl = dst_rdy & (dst_num > dst_cnt);

    always_comb begin
        cnt_d     = cnt_q + CNT_WIDTH'(wr_n) - CNT_WIDTH'(rd_n);
        wptr_d    = wptr_q + ADDR_WIDTH'(wr_n);
        rptr_d    = rptr_q + ADDR_WIDTH'(rd_n);
        src_rdy_d = cnt_d <= CNT_WIDTH'(DEPTH - WR_LANES);
        dst_vld_d = cnt_d != '0;
        afull_d   = cnt_d >= afull_th;
        aempty_d  = cnt_d <= aempty_th;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            src_rdy_q <= 1'b1;
            dst_vld_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            src_rdy_q <= src_rdy_d;
            dst_vld_q <= dst_vld_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    // Storage is deliberately left unreset; the gather masks lanes beyond cnt.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < WR_LANES; i++) begin
                if (i < int'(wr_n)) begin
                    mem_q[wptr_q + ADDR_WIDTH'(i)] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    cm_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LANES   (RD_LANES),
        .DEPTH      (DEPTH)
    ) u_lane_sel (
        .mem      (mem_q),
        .rptr     (rptr_q),
        .lane_cnt (dst_cnt),
        .data     (dst_data)
    );

    assign src_rdy = src_rdy_q;
    assign dst_vld = dst_vld_q;
    assign afull   = afull_q;
    assign aempty  = aempty_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_cm_lane_fifo.sv
// Bench for cm_lane_fifo: directed scenarios then random traffic against a lane-queue model.
module tb_cm_lane_fifo;

    localparam int DW  = 8;
    localparam int WL  = 4;
    localparam int RL  = 4;
    localparam int DP  = 16;
    localparam int CW  = 5;
    localparam int WNW = 3;
    localparam int RNW = 3;
    localparam int AFT = 12;
    localparam int AET = 2;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           src_vld;
    logic [WNW-1:0] src_num;
    logic [31:0]    src_data;
    logic           src_rdy;
    logic           dst_rdy;
    logic [RNW-1:0] dst_num;
    logic           dst_vld;
    logic [31:0]    dst_data;
    logic [RNW-1:0] dst_cnt;
    logic [CW-1:0]  afull_th;
    logic [CW-1:0]  aempty_th;
    logic           afull;
    logic           aempty;
    logic           ovfl;
    logic           udfl;
    logic [CW-1:0]  cnt;

    cm_lane_fifo #(
        .DATA_WIDTH (DW),
        .WR_LANES   (WL),
        .RD_LANES   (RL),
        .DEPTH      (DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_vld   (src_vld),
        .src_num   (src_num),
        .src_data  (src_data),
        .src_rdy   (src_rdy),
        .dst_rdy   (dst_rdy),
        .dst_num   (dst_num),
        .dst_vld   (dst_vld),
        .dst_data  (dst_data),
        .dst_cnt   (dst_cnt),
        .afull_th  (afull_th),
        .aempty_th (aempty_th),
        .afull     (afull),
        .aempty    (aempty),
        .ovfl      (ovfl),
        .udfl      (udfl),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model: the stored lanes, oldest first.
    logic [7:0] mq[$];

    bit          l_rst, l_fl, l_sv, l_dr;
    int          l_sn, l_dn;
    logic [31:0] l_sd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int          n;
        int          dc;
        bit          rdy;
        logic [31:0] ed;
        n   = mq.size();
        dc  = (n < RL) ? n : RL;
        rdy = (DP - n) >= WL;
        ed  = '0;
        for (int i = 0; i < dc; i++) ed[i*DW +: DW] = mq[i];
        chk("cnt",      32'(cnt),      32'(n));
        chk("src_rdy",  32'(src_rdy),  32'(rdy));
        chk("dst_vld",  32'(dst_vld),  32'(n != 0));
        chk("dst_cnt",  32'(dst_cnt),  32'(dc));
        chk("dst_data", dst_data,      ed);
        chk("afull",    32'(afull),    32'(n >= AFT));
        chk("aempty",   32'(aempty),   32'(n <= AET));
        chk("ovfl",     32'(ovfl),     32'(l_sv && !rdy && l_sn != 0));
        chk("udfl",     32'(udfl),     32'(l_dr && l_dn > dc));
    endtask

    task automatic step(input bit r, input bit fl, input bit sv, input int sn,
                        input logic [31:0] sd, input bit dr, input int dn);
        @(negedge clk);
        assert (sn >= 0 && sn <= WL && dn >= 0 && dn <= RL)
        else $fatal(1, "FAIL illegal_num src_num=%0d dst_num=%0d", sn, dn);
        rst      = r;
        flush    = fl;
        src_vld  = sv;
        src_num  = WNW'(sn);
        src_data = sd;
        dst_rdy  = dr;
        dst_num  = RNW'(dn);
        l_rst = r; l_fl = fl; l_sv = sv; l_sn = sn; l_sd = sd; l_dr = dr; l_dn = dn;
        #1;
        if (chk_en) check_all();
    endtask

    task automatic tick();
        int n;
        int dc;
        int rd;
        @(posedge clk);
        if (l_rst || l_fl) begin
            mq.delete();
        end else begin
            n  = mq.size();
            dc = (n < RL) ? n : RL;
            rd = (n != 0 && l_dr) ? ((l_dn < dc) ? l_dn : dc) : 0;
            repeat (rd) void'(mq.pop_front());
            if (l_sv && (DP - n) >= WL)
                for (int i = 0; i < l_sn; i++) mq.push_back(l_sd[i*DW +: DW]);
        end
    endtask

    task automatic cyc(input bit r, input bit fl, input bit sv, input int sn,
                       input logic [31:0] sd, input bit dr, input int dn);
        step(r, fl, sv, sn, sd, dr, dn);
        tick();
    endtask

    initial begin
        int wp;
        rst = 1'b1; flush = 1'b0; src_vld = 1'b0; src_num = '0; src_data = '0;
        dst_rdy = 1'b0; dst_num = '0;
        afull_th = CW'(AFT); aempty_th = CW'(AET);

        // Reset then idle
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt",  32'(cnt), 0);
        chk("rst_data", dst_data, 0);
        tick();

        // Three lanes, visible the following cycle
        cyc(0, 0, 1, 3, 32'h00332211, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("w3_cnt",  32'(dst_cnt), 3);
        chk("w3_data", dst_data, 32'h00332211);
        tick();

        // Fill to 12, then 13, then overflow attempt
        cyc(0, 0, 1, 4, $urandom(), 0, 0);
        cyc(0, 0, 1, 4, $urandom(), 0, 0);
        cyc(0, 0, 1, 1, $urandom(), 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("f12_afull", 32'(afull), 1);
        chk("f12_rdy",   32'(src_rdy), 1);
        tick();
        cyc(0, 0, 1, 1, $urandom(), 0, 0);
        step(0, 0, 1, 2, $urandom(), 0, 0);
        chk("f13_rdy",  32'(src_rdy), 0);
        chk("f13_ovfl", 32'(ovfl), 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("f13_hold", 32'(cnt), 13);
        tick();

        // Drain to 2, then over-read
        cyc(0, 0, 0, 0, 0, 1, 4);
        cyc(0, 0, 0, 0, 0, 1, 4);
        cyc(0, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 1, 4);
        chk("ur_udfl", 32'(udfl), 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("ur_cnt", 32'(cnt), 0);
        chk("ur_vld", 32'(dst_vld), 0);
        tick();

        // Write 4 / read 3 across the address wrap
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 4, $urandom(), 1, 3);
            if (k > 0) chk("wrap_cnt", 32'(cnt), 32'(3 + k));
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_cnt8", 32'(cnt), 8);
        tick();
        cyc(1, 0, 1, 4, $urandom(), 1, 2);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst", 32'(cnt), 0);
        tick();

        // Flush discards a same-cycle write and read
        cyc(0, 0, 1, 4, $urandom(), 0, 0);
        cyc(0, 1, 1, 4, $urandom(), 1, 2);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flush_cnt", 32'(cnt), 0);
        tick();

        // Random traffic, alternating fill-biased and drain-biased phases
        for (int p = 0; p < 6; p++) begin
            wp = (p % 2 == 0) ? 80 : 30;
            for (int c = 0; c < 80; c++) begin
                cyc($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 99) < wp, int'($urandom_range(0, WL)), $urandom(),
                    $urandom_range(0, 99) < (110 - wp), int'($urandom_range(0, RL)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
